// File: rtl/fsm_256to64_if.sv
// Word-in / beat-out handshake bundle for the 256-to-64 serializer.
interface fsm_256to64_if;
    localparam int unsigned WORD_W = 256;
    localparam int unsigned BEAT_W = 64;

    logic              we_in;
    logic [WORD_W-1:0] din;
    logic              in_ready;
    logic              dout_valid;
    logic [BEAT_W-1:0] dout;
    logic              dout_last;
    logic              dout_ready;
    logic              busy;

    modport slave (
        input  we_in, din, dout_ready,
        output in_ready, dout_valid, dout, dout_last, busy
    );

    modport master (
        output we_in, din, dout_ready,
        input  in_ready, dout_valid, dout, dout_last, busy
    );
endinterface

// File: rtl/fsm_256to64.sv
// Serializes 256-bit words into four 64-bit beats, MS beat first, with a
// one-word pending buffer so consecutive words stream without idle beats.
module fsm_256to64 (
    input  logic           clk,
    input  logic           rst,
    fsm_256to64_if.slave   bus
);
    localparam int unsigned WORD_W = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned CNT_W  = 2;

    // Encoding keeps cur_v in bit 0 and pend_v in bit 1; 2'b10 is illegal.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b11
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   cur;
    logic [WORD_W-1:0]   pend;
    logic [CNT_W-1:0]    beat;
    logic [BEAT_W-1:0]   dout_q;

    logic cur_v;
    logic pend_v;
    logic accept;
    logic xfer;
    logic word_done;

    // Beat b of a word lives in lane (3 - b), i.e. the bitwise inverse of b.
    function automatic logic [BEAT_W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  b);
        logic [CNT_W-1:0] idx;
        idx = ~b;
        return w[{idx, 6'd0} +: BEAT_W];
    endfunction

    assign cur_v     = (state == ACTIVE) || (state == FULL);
    assign pend_v    = (state == FULL);
    assign accept    = bus.we_in & ~pend_v;
    assign xfer      = cur_v & bus.dout_ready;
    assign word_done = xfer & (beat == CNT_W'(3));

    assign bus.in_ready   = ~pend_v;
    assign bus.dout_valid = cur_v;
    assign bus.dout       = dout_q;
    assign bus.dout_last  = cur_v & (beat == CNT_W'(3));
    assign bus.busy       = cur_v | pend_v;

    // dout_q always mirrors lane_of(cur, beat) while a word is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            cur    <= '0;
            pend   <= '0;
            beat   <= '0;
            dout_q <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        cur    <= bus.din;
                        beat   <= '0;
                        dout_q <= lane_of(bus.din, '0);
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (word_done) begin
                        beat <= '0;
                        if (accept) begin
                            cur    <= bus.din;
                            dout_q <= lane_of(bus.din, '0);
                        end else begin
                            state <= EMPTY;
                        end
                    end else begin
                        if (xfer) begin
                            beat   <= beat + CNT_W'(1);
                            dout_q <= lane_of(cur, beat + CNT_W'(1));
                        end
                        if (accept) begin
                            pend  <= bus.din;
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    // in_ready is low here, so no new word can arrive this cycle.
                    if (word_done) begin
                        cur    <= pend;
                        beat   <= '0;
                        dout_q <= lane_of(pend, '0);
                        state  <= ACTIVE;
                    end else if (xfer) begin
                        beat   <= beat + CNT_W'(1);
                        dout_q <= lane_of(cur, beat + CNT_W'(1));
                    end
                end
                default: begin
                    state <= EMPTY;
                    beat  <= '0;
                end
            endcase
        end
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.dout_valid && !bus.dout_ready) |=> (bus.dout_valid && $stable(bus.dout)))
        else $error("dout changed during stall");

    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        (state == EMPTY) || (state == ACTIVE) || (state == FULL))
        else $error("pending word held without current word");

endmodule

// File: tb/tb_fsm_256to64.sv
// Bench for fsm_256to64: directed vector table, back-to-back streaming and a
// randomized run, all checked against a queue-based word/beat scoreboard.
module tb_fsm_256to64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_256to64_if bus();

    fsm_256to64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           r;
        bit           we;
        logic [255:0] d;
        bit           rdy;
        bit           e_in_ready;
        bit           e_valid;
        bit           chk_dout;
        logic [63:0]  e_dout;
        bit           e_last;
        bit           e_busy;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] m_q[$];
    int           m_beat = 0;
    logic [255:0] asm_word = '0;
    int           words_out = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] rep4(input logic [3:0] n);
        return {16{n}};
    endfunction

    function automatic logic [63:0] rep8(input logic [7:0] n);
        return {8{n}};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic vec_t mk(input bit r, input bit we, input logic [255:0] d, input bit rdy,
                                input bit iv, input bit v, input bit cd, input logic [63:0] e,
                                input bit l, input bit b);
        vec_t x;
        x.r = r; x.we = we; x.d = d; x.rdy = rdy;
        x.e_in_ready = iv; x.e_valid = v; x.chk_dout = cd; x.e_dout = e;
        x.e_last = l; x.e_busy = b;
        return x;
    endfunction

    // Scoreboard expectations for the current cycle, from the word queue.
    task automatic model_check();
        logic [255:0] sh;
        logic [63:0]  exp_lane;
        chk1("in_ready", bus.in_ready, m_q.size() < 2);
        chk1("dout_valid", bus.dout_valid, m_q.size() > 0);
        chk1("busy", bus.busy, m_q.size() > 0);
        chk1("dout_last", bus.dout_last, (m_q.size() > 0) && (m_beat == 3));
        chk1("no_pend_without_cur", !(!bus.dout_valid && !bus.in_ready), 1'b1);
        if (m_q.size() > 0) begin
            sh = m_q[0] >> (64 * (3 - m_beat));
            exp_lane = sh[63:0];
            chk64("dout", bus.dout, exp_lane);
        end
    endtask

    task automatic model_step(input bit r, input bit we, input logic [255:0] d,
                              input bit rdy, input logic [63:0] obs_dout);
        bit acc;
        if (r) begin
            m_q.delete();
            m_beat = 0;
            return;
        end
        acc = we && (m_q.size() < 2);
        if (m_q.size() > 0 && rdy) begin
            asm_word = {asm_word[191:0], obs_dout};
            if (m_beat == 3) begin
                chk256("word", asm_word, m_q[0]);
                words_out++;
                void'(m_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (acc) m_q.push_back(d);
    endtask

    // Called just after a falling edge: check, drive, advance the scoreboard.
    task automatic run_cycle(input bit r, input bit we, input logic [255:0] d, input bit rdy,
                             output bit acc, output bit vld);
        logic [63:0] obs;
        model_check();
        acc = we && bus.in_ready && !r;
        vld = bus.dout_valid;
        obs = bus.dout;
        rst = r;
        bus.we_in = we;
        bus.din = d;
        bus.dout_ready = rdy;
        model_step(r, we, d, rdy, obs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w1, wp, wx, wy, wr1, wr2, cand, d;
        logic [255:0] bw[3];
        bit acc, vld, we, rdy;
        int idx, c_cyc, vcnt, first, last, low, words_in, cyc;

        bus.we_in = 1'b0;
        bus.din = '0;
        bus.dout_ready = 1'b0;

        w1  = {rep4(4'h1), rep4(4'h2), rep4(4'h3), rep4(4'h4)};
        wp  = {rep8(8'h01), rep8(8'h02), rep8(8'h03), rep8(8'h04)};
        wx  = {rep4(4'h5), rep4(4'h6), rep4(4'h7), rep4(4'h8)};
        wy  = {rep4(4'h9), rep8(8'h3c), rep8(8'hc3), rep4(4'hd)};
        wr1 = {rep4(4'he), rep4(4'hf), rep8(8'h12), rep8(8'h34)};
        wr2 = {4{rep8(8'h5a)}};

        // single word, then idle
        tbl.push_back(mk(0, 1, w1, 1,  1, 0, 1, 64'h0,      0, 0));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h1), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h2), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h3), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h4), 1, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 0, 0, 64'h0,      0, 0));
        // backpressure 1,0,0,1,0,1,1
        tbl.push_back(mk(0, 1, wp, 1,  1, 0, 0, 64'h0,       0, 0));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'h01), 0, 1));
        tbl.push_back(mk(0, 0, '0, 0,  1, 1, 1, rep8(8'h02), 0, 1));
        tbl.push_back(mk(0, 0, '0, 0,  1, 1, 1, rep8(8'h02), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'h02), 0, 1));
        tbl.push_back(mk(0, 0, '0, 0,  1, 1, 1, rep8(8'h03), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'h03), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'h04), 1, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 0, 0, 64'h0,       0, 0));
        // next word offered on the last-beat cycle with pend empty
        tbl.push_back(mk(0, 1, wx, 1,  1, 0, 0, 64'h0,       0, 0));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h5),  0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h6),  0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h7),  0, 1));
        tbl.push_back(mk(0, 1, wy, 1,  1, 1, 1, rep4(4'h8),  1, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'h9),  0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'h3c), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep8(8'hc3), 0, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 1, 1, rep4(4'hd),  1, 1));
        tbl.push_back(mk(0, 0, '0, 1,  1, 0, 0, 64'h0,       0, 0));
        // reset after beat1 with a pending word held
        tbl.push_back(mk(0, 1, wr1, 1, 1, 0, 0, 64'h0,       0, 0));
        tbl.push_back(mk(0, 1, wr2, 1, 1, 1, 1, rep4(4'he),  0, 1));
        tbl.push_back(mk(0, 0, '0,  1, 0, 1, 1, rep4(4'hf),  0, 1));
        tbl.push_back(mk(1, 0, '0,  1, 0, 1, 1, rep8(8'h12), 0, 1));
        tbl.push_back(mk(0, 0, '0,  1, 1, 0, 1, 64'h0,       0, 0));
        tbl.push_back(mk(0, 0, '0,  1, 1, 0, 1, 64'h0,       0, 0));
        tbl.push_back(mk(0, 0, '0,  1, 1, 0, 1, 64'h0,       0, 0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            chk1($sformatf("tbl%0d.in_ready", i), bus.in_ready, tbl[i].e_in_ready);
            chk1($sformatf("tbl%0d.dout_valid", i), bus.dout_valid, tbl[i].e_valid);
            chk1($sformatf("tbl%0d.dout_last", i), bus.dout_last, tbl[i].e_last);
            chk1($sformatf("tbl%0d.busy", i), bus.busy, tbl[i].e_busy);
            if (tbl[i].chk_dout)
                chk64($sformatf("tbl%0d.dout", i), bus.dout, tbl[i].e_dout);
            run_cycle(tbl[i].r, tbl[i].we, tbl[i].d, tbl[i].rdy, acc, vld);
        end

        // three back-to-back words with we_in held and no backpressure
        bw[0] = {4{rep4(4'ha)}};
        bw[1] = {4{rep4(4'hb)}};
        bw[2] = {4{rep4(4'hc)}};
        idx = 0; c_cyc = -1; vcnt = 0; first = -1; last = -1; low = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (!bus.in_ready) low++;
            d = (idx < 3) ? bw[idx] : '0;
            run_cycle(0, idx < 3, d, 1, acc, vld);
            if (vld) begin
                vcnt++;
                if (first < 0) first = k;
                last = k;
            end
            if (acc) begin
                if (idx == 2) c_cyc = k;
                idx++;
            end
        end
        chki("b2b_valid_beats", vcnt, 12);
        chki("b2b_first_beat", first, 1);
        chki("b2b_span", last - first + 1, 12);
        chki("b2b_in_ready_low", low, 6);
        chki("b2b_c_accept_cycle", c_cyc, 5);

        // randomized handshakes
        words_out = 0;
        words_in = 0;
        cyc = 0;
        cand = rnd256();
        while (words_in < 1000 && cyc < 40000) begin
            we  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            run_cycle(0, we, cand, rdy, acc, vld);
            if (acc) begin
                words_in++;
                cand = rnd256();
            end
            cyc++;
        end
        for (int k = 0; k < 64 && m_q.size() > 0; k++) begin
            @(negedge clk);
            run_cycle(0, 0, '0, 1, acc, vld);
        end
        @(negedge clk);
        model_check();
        chki("rand_words_in", words_in, 1000);
        chki("rand_words_out", words_out, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
